// File: rtl/actuated_traffic_controller_if.sv
// rtl/actuated_traffic_controller_if.sv - road sensor/request inputs and lamp outputs of the traffic controller
interface actuated_traffic_controller_if;
  logic       ew_sensor;
  logic       ped_req;
  logic       flash_mode;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_walk;

  // master drives sensors/requests and watches lamps; slave is the controller
  modport master (
    output ew_sensor, ped_req, flash_mode,
    input  ns_light, ew_light, ped_walk
  );

  modport slave (
    input  ew_sensor, ped_req, flash_mode,
    output ns_light, ew_light, ped_walk
  );
endinterface

// File: rtl/actuated_traffic_controller.sv
// rtl/actuated_traffic_controller.sv - actuated two-road traffic light controller with walk and flash modes
module actuated_traffic_controller #(
  parameter int GREEN_MIN   = 8,
  parameter int GREEN_MAX   = 16,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int PED_WALK    = 5,
  parameter int FLASH_HALF  = 4,
  parameter int CNT_W       = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  actuated_traffic_controller_if.slave  tl
);

  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, ALL_RED_1, EW_GREEN, EW_YELLOW, ALL_RED_2, FLASH
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam logic [CNT_W-1:0] GMIN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] WALK_LEN   = CNT_W'(PED_WALK);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ew_demand_q, ew_demand_d;
  logic             ped_pending_q, ped_pending_d;
  logic             walk_grant_q, walk_grant_d;
  logic             flash_phase_q, flash_phase_d;

  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_walk;

  // state, timer and latched requests; reset parks the junction in all-red clearance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ALL_RED_2;
      timer_q       <= '0;
      ew_demand_q   <= 1'b0;
      ped_pending_q <= 1'b0;
      walk_grant_q  <= 1'b0;
      flash_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ew_demand_q   <= ew_demand_d;
      ped_pending_q <= ped_pending_d;
      walk_grant_q  <= walk_grant_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  // next-state, timer and request latching; a request seen this cycle counts immediately
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + 1'b1;
    ew_demand_d   = ew_demand_q   | (tl.ew_sensor && state_q != EW_GREEN);
    ped_pending_d = ped_pending_q | (tl.ped_req   && state_q != EW_GREEN);
    walk_grant_d  = walk_grant_q;
    flash_phase_d = flash_phase_q;

    case (state_q)
      NS_GREEN: begin
        if (timer_q >= GMIN_LAST) begin
          if (ew_demand_d || ped_pending_d || tl.flash_mode) begin
            state_d = NS_YELLOW;
            timer_d = '0;
          end else begin
            // resting green: hold the timer so the minimum stays satisfied
            timer_d = GMIN_LAST;
          end
        end
      end
      NS_YELLOW: begin
        if (timer_q == YEL_LAST) begin
          state_d = ALL_RED_1;
          timer_d = '0;
        end
      end
      ALL_RED_1: begin
        if (timer_q == AR_LAST) begin
          timer_d = '0;
          if (tl.flash_mode) begin
            state_d       = FLASH;
            flash_phase_d = 1'b1;
          end else begin
            // entering EW green consumes the requests; clear beats a same-cycle set
            state_d       = EW_GREEN;
            walk_grant_d  = ped_pending_d;
            ew_demand_d   = 1'b0;
            ped_pending_d = 1'b0;
          end
        end
      end
      EW_GREEN: begin
        if (timer_q == GMAX_LAST ||
            (timer_q >= GMIN_LAST && (!tl.ew_sensor || tl.flash_mode))) begin
          state_d = EW_YELLOW;
          timer_d = '0;
        end
      end
      EW_YELLOW: begin
        if (timer_q == YEL_LAST) begin
          state_d = ALL_RED_2;
          timer_d = '0;
        end
      end
      ALL_RED_2: begin
        if (timer_q == AR_LAST) begin
          timer_d = '0;
          if (tl.flash_mode) begin
            state_d       = FLASH;
            flash_phase_d = 1'b1;
          end else begin
            state_d = NS_GREEN;
          end
        end
      end
      FLASH: begin
        if (!tl.flash_mode) begin
          state_d = ALL_RED_2;
          timer_d = '0;
        end else if (timer_q == FLASH_LAST) begin
          flash_phase_d = ~flash_phase_q;
          timer_d       = '0;
        end
      end
      default: begin
        state_d = ALL_RED_2;
        timer_d = '0;
      end
    endcase
  end

  // Moore lamp decode from registered state only
  always_comb begin
    ns_light = RED;
    ew_light = RED;
    ped_walk = 1'b0;
    case (state_q)
      NS_GREEN:  ns_light = GRN;
      NS_YELLOW: ns_light = YEL;
      EW_GREEN: begin
        ew_light = GRN;
        ped_walk = walk_grant_q && (timer_q < WALK_LEN);
      end
      EW_YELLOW: ew_light = YEL;
      FLASH: begin
        ns_light = flash_phase_q ? YEL : OFF;
        ew_light = flash_phase_q ? RED : OFF;
      end
      default: begin
        ns_light = RED;
        ew_light = RED;
      end
    endcase
  end

  assign tl.ns_light = ns_light;
  assign tl.ew_light = ew_light;
  assign tl.ped_walk = ped_walk;

endmodule

// File: tb/tb_actuated_traffic_controller.sv
// tb/tb_actuated_traffic_controller.sv - directed bench for the actuated traffic controller
module tb_actuated_traffic_controller;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic clk = 1'b0;
  logic reset_n;

  int n_cmp = 0;
  int n_bad = 0;

  actuated_traffic_controller_if tl_if ();

  actuated_traffic_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tl      (tl_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] ns, input logic [2:0] ew, input logic pw);
    n_cmp++;
    assert ({tl_if.ns_light, tl_if.ew_light, tl_if.ped_walk} === {ns, ew, pw}) else begin
      n_bad++;
      $error("FAIL %s: observed ns=%b ew=%b walk=%b expected ns=%b ew=%b walk=%b",
             tag, tl_if.ns_light, tl_if.ew_light, tl_if.ped_walk, ns, ew, pw);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                     input logic pw, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, ns, ew, pw);
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    tl_if.ew_sensor  = 1'b0;
    tl_if.ped_req    = 1'b0;
    tl_if.flash_mode = 1'b0;

    @(negedge clk);
    chk("in_reset", RED, RED, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run("boot_allred", RED, RED, 1'b0, 2);
    run("ns_rest", GRN, RED, 1'b0, 110);

    tl_if.ew_sensor = 1'b1;
    run("t2_pulse", GRN, RED, 1'b0, 1);
    tl_if.ew_sensor = 1'b0;
    run("t2_ns_yel", YEL, RED, 1'b0, 3);
    run("t2_allred1", RED, RED, 1'b0, 2);
    run("t2_ew_grn", RED, GRN, 1'b0, 8);
    run("t2_ew_yel", RED, YEL, 1'b0, 3);
    run("t2_allred2", RED, RED, 1'b0, 2);
    run("t2_ns_rest", GRN, RED, 1'b0, 20);

    tl_if.ew_sensor = 1'b1;
    run("t3_ns_last", GRN, RED, 1'b0, 1);
    run("t3_ns_yel", YEL, RED, 1'b0, 3);
    run("t3_allred1", RED, RED, 1'b0, 2);
    run("t3_ew_max", RED, GRN, 1'b0, 16);
    run("t3_ew_yel", RED, YEL, 1'b0, 3);
    run("t3_allred2", RED, RED, 1'b0, 2);
    run("t3_ns_min", GRN, RED, 1'b0, 8);
    run("t3_ns_yel2", YEL, RED, 1'b0, 3);
    run("t3_allred1b", RED, RED, 1'b0, 2);
    tl_if.ew_sensor = 1'b0;
    run("t3_ew_short", RED, GRN, 1'b0, 8);
    run("t3_ew_yel2", RED, YEL, 1'b0, 3);
    run("t3_allred2b", RED, RED, 1'b0, 2);
    run("t3_ns_rest", GRN, RED, 1'b0, 20);

    tl_if.ped_req = 1'b1;
    run("t4_req", GRN, RED, 1'b0, 1);
    tl_if.ped_req = 1'b0;
    run("t4_ns_yel", YEL, RED, 1'b0, 3);
    run("t4_allred1", RED, RED, 1'b0, 2);
    run("t4_walk", RED, GRN, 1'b1, 2);
    tl_if.ped_req = 1'b1;
    run("t4_walk_req2", RED, GRN, 1'b1, 1);
    tl_if.ped_req = 1'b0;
    run("t4_walk_tail", RED, GRN, 1'b1, 2);
    run("t4_ew_nowalk", RED, GRN, 1'b0, 3);
    run("t4_ew_yel", RED, YEL, 1'b0, 3);
    run("t4_allred2", RED, RED, 1'b0, 2);
    run("t4_ns_rest", GRN, RED, 1'b0, 20);

    tl_if.flash_mode = 1'b1;
    run("t5_ns_last", GRN, RED, 1'b0, 1);
    run("t5_ns_yel", YEL, RED, 1'b0, 3);
    run("t5_allred1", RED, RED, 1'b0, 2);
    for (int k = 0; k < 2; k++) begin
      run("t5_flash_on", YEL, RED, 1'b0, 4);
      run("t5_flash_off", OFF, OFF, 1'b0, 4);
    end
    tl_if.flash_mode = 1'b0;
    run("t5_flash_exit", YEL, RED, 1'b0, 1);
    run("t5_allred2", RED, RED, 1'b0, 2);
    run("t5_ns_rest", GRN, RED, 1'b0, 20);

    tl_if.ped_req   = 1'b1;
    tl_if.ew_sensor = 1'b1;
    run("t6_req", GRN, RED, 1'b0, 1);
    tl_if.ped_req = 1'b0;
    run("t6_ns_yel", YEL, RED, 1'b0, 3);
    run("t6_allred1", RED, RED, 1'b0, 2);
    run("t6_walk", RED, GRN, 1'b1, 2);
    chk("t6_pre_reset", RED, GRN, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_reset", RED, RED, 1'b0);
    tl_if.ew_sensor = 1'b0;
    @(negedge clk);
    chk("t6_reset_held", RED, RED, 1'b0);
    reset_n = 1'b1;
    run("t6_boot_allred", RED, RED, 1'b0, 2);
    run("t6_ns_rest", GRN, RED, 1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/actuated_traffic_controller.md
Name: actuated_traffic_controller

Overview:
- Parametrised successor to the fixed-cycle two-road traffic light controller.
- Serves an NS main road and an EW side road.
- Adds programmable phase timing, a sensor-actuated EW green with min/max limits, a pedestrian walk request and a night flashing mode.
- Light outputs keep the team's 3-bit R-Y-G encoding, so existing top-levels and monitors drop in unchanged.

Parameters:
- GREEN_MIN, 8, minimum green duration in clk cycles for either road (>= PED_WALK, >= 1).
- GREEN_MAX, 16, maximum EW green duration in cycles (>= GREEN_MIN).
- YELLOW_TIME, 3, yellow duration in cycles (>= 1).
- ALLRED_TIME, 2, all-red clearance duration in cycles (>= 1).
- PED_WALK, 5, cycles ped_walk is asserted at the start of a granted EW green.
- FLASH_HALF, 4, cycles per half-period of flashing mode.
- CNT_W, 5, phase timer width; must hold max(GREEN_MAX, FLASH_HALF) - 1.

Ports:
- clk, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- ew_sensor, input, 1, EW vehicle presence (level, synchronous to clk).
- ped_req, input, 1, pedestrian request (pulse or level; any high cycle counts).
- flash_mode, input, 1, request night flashing mode (level).
- ns_light, output, 3, NS lamp: {R,Y,G}. RED=100, YEL=010, GRN=001, OFF=000.
- ew_light, output, 3, EW lamp, same encoding.
- ped_walk, output, 1, walk signal for pedestrians crossing NS road.

Behaviour:
- Moore machine. Outputs decode combinationally from registered state/timer/flags only; no input-to-output paths.
- States and lamp outputs:
  - NS_GREEN: NS=001, EW=100.
  - NS_YELLOW: NS=010, EW=100.
  - ALL_RED_1: both 100.
  - EW_GREEN: NS=100, EW=001.
  - EW_YELLOW: NS=100, EW=010.
  - ALL_RED_2: both 100.
  - FLASH: phase=1 gives NS=010, EW=100; phase=0 gives both 000.
- Timer: cleared to 0 on every state entry; increments each cycle. "Lasts D cycles" means the transition fires when timer==D-1.
- Reset (async, any time, including mid-phase):
  - state=ALL_RED_2, timer=0.
  - ew_demand=0, ped_pending=0, walk_grant=0, flash_phase=0.
  - Outputs immediately NS=100, EW=100, ped_walk=0.
- Latches:
  - ew_demand: set by ew_sensor=1 in any state except EW_GREEN; cleared on EW_GREEN entry.
  - ped_pending: set by ped_req=1 in any state except EW_GREEN; cleared on EW_GREEN entry.
  - Set and clear in the same cycle resolves to clear.
- walk_grant: on EW_GREEN entry, loaded with ped_pending (including a request in the entry cycle).
- ped_walk = (state==EW_GREEN) && walk_grant && timer<PED_WALK. It is 0 in all other states.
- Transitions:
  - NS_GREEN -> NS_YELLOW when timer>=GREEN_MIN-1 and (ew_demand | ped_pending | flash_mode). Otherwise NS rests in green indefinitely; timer saturates at GREEN_MIN-1.
  - NS_YELLOW -> ALL_RED_1 after YELLOW_TIME cycles.
  - ALL_RED_1 -> FLASH if flash_mode=1, else -> EW_GREEN, after ALLRED_TIME cycles.
  - EW_GREEN -> EW_YELLOW when timer==GREEN_MAX-1, or when timer>=GREEN_MIN-1 and (ew_sensor==0 | flash_mode).
  - EW_YELLOW -> ALL_RED_2 after YELLOW_TIME cycles.
  - ALL_RED_2 -> FLASH if flash_mode=1, else -> NS_GREEN, after ALLRED_TIME cycles.
  - FLASH: flash_phase=1 on entry, toggles each time timer==FLASH_HALF-1 (timer then clears). When flash_mode=0 is sampled: -> ALL_RED_2, timer=0.
- Sequencing rules:
  - Green never shorter than GREEN_MIN. EW green never longer than GREEN_MAX.
  - Yellow and all-red clearance are never skipped, including when entering or leaving FLASH.
  - Demand arriving during EW_YELLOW/ALL_RED_2 is held and served after the next NS minimum green.

Test Plan:
- Reset release, all inputs 0 -> both 100 for exactly 2 cycles, then NS=001/EW=100 held for 100+ cycles; ped_walk=0 throughout.
- Single-cycle ew_sensor pulse 20 cycles into NS green -> next edge NS=010 for 3 cycles, both 100 for 2, EW=001 for 8, EW=010 for 3, both 100 for 2, then NS=001 resting.
- ew_sensor held 1 continuously -> EW=001 exactly 16 cycles. Demand re-latches during yellow, so NS=001 lasts exactly 8 cycles before the next NS=010; cycle repeats.
- One-cycle ped_req pulse with ew_sensor=0 -> EW=001 for 8 cycles, ped_walk=1 on its first 5 cycles only. A second ped_req during that EW green is ignored (no extra EW phase).
- flash_mode=1 during resting NS green -> NS=010 for 3 cycles, both 100 for 2, then 4 cycles NS=010/EW=100 alternating with 4 cycles 000/000. On flash_mode=0 -> both 100 for 2 cycles, then NS=001.
- reset_n pulled low asynchronously mid-EW_GREEN with ped_walk=1 -> outputs go to 100/100 and ped_walk=0 before the next clk edge. Latched demand is lost: after release, 2 cycles all-red then NS=001 resting.
